// File: rtl/ldo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ldo_pkg
//  Description : Shared definitions for the digital-LDO pass-array control
//                loop: controller state encoding, decision direction
//                encoding and the count-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package ldo_pkg;

    // Controller states; the numeric values are visible on ldoctl_state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SSTART = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } ldo_state_e;

    // Comparator decision direction: 1 means Vout is low, more legs needed.
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Width needed to hold a leg count in the range 0..n_pass.
    function automatic int count_width(input int n_pass);
        return $clog2(n_pass + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ldo_therm_dec.sv
`default_nettype none
// ============================================================================
//  Module      : ldo_therm_dec
//  Description : Registered leg-count to active-low thermometer decoder.
//                gate_o[i] = 0 (leg on) when i < count. The flop samples the
//                next-state count so the gate vector changes on the same edge
//                as the count register that feeds it.
//  Ports       : clk_i    - clock
//                rst_ni   - asynchronous active-low reset (all legs off)
//                count_i  - next-state leg count, 0..N_PASS
//                gate_o   - registered active-low gate vector
//  Revision    : 1.0  initial release
// ============================================================================
module ldo_therm_dec
    import ldo_pkg::*;
#(
    parameter int N_PASS = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [count_width(N_PASS)-1:0]    count_i,
    output logic [N_PASS-1:0]                 gate_o
);

    localparam int CW = count_width(N_PASS);

    logic [N_PASS-1:0] gate_d;
    logic [N_PASS-1:0] gate_q;

    for (genvar i = 0; i < N_PASS; i++) begin : g_leg
        assign gate_d[i] = ~(count_i > CW'(i));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gate_q <= '1;
        end else begin
            gate_q <= gate_d;
        end
    end

    assign gate_o = gate_q;

endmodule
`default_nettype wire

// File: rtl/ldo_pass_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ldo_pass_ctrl
//  Description : Digital LDO control loop for an N_PASS-leg PMOS pass array.
//                Once every DIV clocks it consumes one comparator decision
//                and moves a thermometer leg count up or down, with coarse
//                steps on long same-direction runs and a limit-cycle lock
//                that freezes the count while the loop dithers.
//  Build option: LDOCTL_SOFTSTART_EN - when defined, enable enters a
//                soft-start ramp (+1 leg per tick from 0) instead of loading
//                INIT_CNT directly into tracking.
//  Ports       : ldoctl_clk    - clock (shared with the comparator)
//                ldoctl_rst    - asynchronous active-low reset
//                ldoctl_en     - loop enable
//                ldoctl_real   - decision, 1 = Vout below Vref
//                ldoctl_fake   - complementary latch output (valid if != real)
//                ldoctl_gate   - active-low thermometer gate vector
//                ldoctl_count  - legs on
//                ldoctl_state  - 0 IDLE, 1 SSTART, 2 TRACK, 3 LOCKED
//                ldoctl_lock   - high in LOCKED
//                ldoctl_sat_hi - count == N_PASS
//                ldoctl_sat_lo - count == 0
//  Revision    : 1.0  initial release
// ============================================================================
module ldo_pass_ctrl
    import ldo_pkg::*;
#(
    parameter int N_PASS      = 32,
    parameter int DIV         = 4,
    parameter int INIT_CNT    = 16,
    parameter int COARSE_STEP = 4,
    parameter int COARSE_RUN  = 3,
    parameter int LOCK_ALT    = 4,
    parameter int UNLOCK_RUN  = 2
) (
    input  logic                            ldoctl_clk,
    input  logic                            ldoctl_rst,
    input  logic                            ldoctl_en,
    input  logic                            ldoctl_real,
    input  logic                            ldoctl_fake,
    output logic [N_PASS-1:0]               ldoctl_gate,
    output logic [count_width(N_PASS)-1:0]  ldoctl_count,
    output logic [1:0]                      ldoctl_state,
    output logic                            ldoctl_lock,
    output logic                            ldoctl_sat_hi,
    output logic                            ldoctl_sat_lo
);

    localparam int CW      = count_width(N_PASS);
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RUN_MAX = (COARSE_RUN > UNLOCK_RUN) ? COARSE_RUN : UNLOCK_RUN;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int ALT_W   = $clog2(LOCK_ALT + 1);

    ldo_state_e         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [RUN_W-1:0]   run_q, run_d, run_nx;
    logic [ALT_W-1:0]   alt_q, alt_d, alt_nx;
    logic               last_q, last_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               lock_q, sat_hi_q, sat_lo_q;
    logic [CW-1:0]      step;

    logic w_tick, w_valid, w_dir, w_same;

    assign w_tick  = (div_q == DIV_W'(DIV - 1));
    assign w_valid = ldoctl_real ^ ldoctl_fake;
    assign w_dir   = ldoctl_real;
    assign w_same  = (w_dir == last_q);

    // Signed add/subtract one count-width wider than the count, clamped to
    // the legal leg range so saturation holds rather than wraps.
    function automatic logic [CW-1:0] step_count(input logic [CW-1:0] cnt,
                                                 input logic          dir,
                                                 input logic [CW-1:0] stp);
        logic signed [CW:0] sum;
        if (dir == DIR_UP) sum = $signed({1'b0, cnt}) + $signed({1'b0, stp});
        else               sum = $signed({1'b0, cnt}) - $signed({1'b0, stp});
        if (sum[CW])                                return '0;
        else if (sum > $signed((CW+1)'(N_PASS)))    return CW'(N_PASS);
        else                                        return sum[CW-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        run_d   = run_q;
        alt_d   = alt_q;
        last_d  = last_q;
        div_d   = div_q;
        run_nx  = run_q;
        alt_nx  = alt_q;
        step    = CW'(1);

        if (!ldoctl_en) begin
            // Disable wins over any coincident tick.
            state_d = ST_IDLE;
            count_d = '0;
            run_d   = '0;
            alt_d   = '0;
            last_d  = DIR_DN;
            div_d   = '0;
        end else begin
            if (state_q != ST_IDLE) begin
                div_d = w_tick ? '0 : div_q + DIV_W'(1);
            end

            unique case (state_q)
                ST_IDLE: begin
                    div_d = '0;
`ifdef LDOCTL_SOFTSTART_EN
                    state_d = ST_SSTART;
                    count_d = '0;
`else
                    state_d = ST_TRACK;
                    count_d = CW'(INIT_CNT);
`endif
                end

                ST_SSTART: begin
                    if (w_tick) begin
                        // A valid down only ends the ramp; it does not step.
                        if (w_valid && (w_dir == DIR_DN)) begin
                            state_d = ST_TRACK;
                            run_d   = '0;
                            alt_d   = '0;
                        end else begin
                            count_d = count_q + CW'(1);
                            if (count_q + CW'(1) == CW'(N_PASS)) begin
                                state_d = ST_TRACK;
                                run_d   = '0;
                                alt_d   = '0;
                            end
                        end
                    end
                end

                ST_TRACK: begin
                    if (w_tick && w_valid) begin
                        if (w_same) begin
                            run_nx = (run_q >= RUN_W'(COARSE_RUN)) ? RUN_W'(COARSE_RUN)
                                                                   : run_q + RUN_W'(1);
                            alt_nx = '0;
                        end else begin
                            run_nx = RUN_W'(1);
                            alt_nx = alt_q + ALT_W'(1);
                        end
                        step    = (run_nx >= RUN_W'(COARSE_RUN)) ? CW'(COARSE_STEP) : CW'(1);
                        count_d = step_count(count_q, w_dir, step);
                        last_d  = w_dir;
                        // The lock-entering tick still applies its step.
                        if (alt_nx == ALT_W'(LOCK_ALT)) begin
                            state_d = ST_LOCKED;
                            run_d   = '0;
                            alt_d   = '0;
                        end else begin
                            run_d   = run_nx;
                            alt_d   = alt_nx;
                        end
                    end
                end

                ST_LOCKED: begin
                    if (w_tick && w_valid) begin
                        run_nx = w_same ? run_q + RUN_W'(1) : RUN_W'(1);
                        run_d  = run_nx;
                        last_d = w_dir;
                        if (run_nx == RUN_W'(UNLOCK_RUN)) begin
                            state_d = ST_TRACK;
                            count_d = step_count(count_q, w_dir, CW'(1));
                        end
                    end
                end

                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ldoctl_clk or negedge ldoctl_rst) begin
        if (!ldoctl_rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            run_q    <= '0;
            alt_q    <= '0;
            last_q   <= DIR_DN;
            div_q    <= '0;
            lock_q   <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            run_q    <= run_d;
            alt_q    <= alt_d;
            last_q   <= last_d;
            div_q    <= div_d;
            lock_q   <= (state_d == ST_LOCKED);
            sat_hi_q <= (count_d == CW'(N_PASS));
            sat_lo_q <= (count_d == '0);
        end
    end

    ldo_therm_dec #(
        .N_PASS (N_PASS)
    ) u_therm_dec (
        .clk_i   (ldoctl_clk),
        .rst_ni  (ldoctl_rst),
        .count_i (count_d),
        .gate_o  (ldoctl_gate)
    );

    assign ldoctl_count  = count_q;
    assign ldoctl_state  = state_q;
    assign ldoctl_lock   = lock_q;
    assign ldoctl_sat_hi = sat_hi_q;
    assign ldoctl_sat_lo = sat_lo_q;

endmodule
`default_nettype wire
